// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the prioritised interrupt controller.
// Holds the FSM state encoding and the lowest-set-bit priority function.
package irq_ctrl_pkg;

  localparam int MAX_SRC  = 32;
  localparam int MAX_ID_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Scans downward so the lowest set index within width wins.
  function automatic logic [MAX_ID_W-1:0] lsb_idx(
    input logic [MAX_SRC-1:0] v,
    input int                 width
  );
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SRC-1; i >= 0; i--) begin
      if (i < width && v[i]) idx = MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_cell.sv
// Per-source edge detector, pending bit and sticky overflow flag.
// Edge mode latches rises; level mode simply mirrors the line.
module irq_src_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  input  logic claim,
  output logic pending,
  output logic ovf
);

  logic src_d;
  logic rise;
  logic clear;

  assign rise  = src & ~src_d;
  assign clear = clr | claim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_d   <= 1'b0;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      src_d <= src;
      if (edge_mode) begin
        // A new rise always wins over a same-cycle clear.
        if (rise) begin
          pending <= 1'b1;
        end else if (clear) begin
          pending <= 1'b0;
        end
        if (rise && pending && !clear) begin
          ovf <= 1'b1;
        end else if (clr) begin
          ovf <= 1'b0;
        end
      end else begin
        pending <= src;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_prio.sv
// N-source interrupt controller with fixed priority (index 0 highest)
// and an ack/eoi claim-complete handshake to one CPU irq line.
module irq_ctrl_prio
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  localparam int ID_W   = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] cfg_edge,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic [NUM_SRC-1:0] clr_vec,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  input  logic               ack,
  input  logic               eoi,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service,
  output logic [NUM_SRC-1:0] ovf
);

  state_e             state;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] claim;
  logic [MAX_SRC-1:0] req_ext;
  logic [ID_W-1:0]    winner;
  logic               cur_req;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      irq_src_cell u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (irq_src[g]),
        .edge_mode (cfg_edge[g]),
        .clr       (clr_vec[g]),
        .claim     (claim[g]),
        .pending   (pending[g]),
        .ovf       (ovf[g])
      );
    end
  endgenerate

  assign req     = pending & irq_en;
  assign cur_req = req[irq_id];

  always_comb begin
    req_ext = '0;
    req_ext[NUM_SRC-1:0] = req;
  end

  assign winner = ID_W'(lsb_idx(req_ext, NUM_SRC));

  // Claim only fires on a live request; a withdraw beats a coinciding ack.
  always_comb begin
    claim = '0;
    if (state == REQ && ack && cur_req) begin
      claim[irq_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      irq_out    <= 1'b0;
      irq_id     <= '0;
      in_service <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= REQ;
            irq_id  <= winner;
            irq_out <= 1'b1;
          end
        end
        REQ: begin
          if (!cur_req) begin
            state   <= IDLE;
            irq_out <= 1'b0;
          end else if (ack) begin
            state              <= SERVICE;
            irq_out            <= 1'b0;
            in_service         <= '0;
            in_service[irq_id] <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state      <= IDLE;
            in_service <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          irq_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
